// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, FSM state encoding, mux codes and
// instruction-length helper shared by the CPU control path.
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_IN   = 4'h1;
    localparam logic [3:0] OP_OUT  = 4'h2;
    localparam logic [3:0] OP_MOVA = 4'h3;
    localparam logic [3:0] OP_MOVR = 4'h4;
    localparam logic [3:0] OP_LDI  = 4'h5;
    localparam logic [3:0] OP_ALU  = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_JZ   = 4'h8;
    localparam logic [3:0] OP_JPOS = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] MUX_ALU  = 2'd0;
    localparam logic [1:0] MUX_RF   = 2'd1;
    localparam logic [1:0] MUX_IMM  = 2'd2;
    localparam logic [1:0] MUX_USER = 2'd3;

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_FETCH_OP = 3'd2,
        S_LOAD_OP  = 3'd3,
        S_EXECUTE  = 3'd4,
        S_WAIT_IN  = 3'd5,
        S_HALT     = 3'd6
    } state_t;

    function automatic logic is_two_byte(input logic [3:0] opcode);
        return opcode inside {OP_LDI, OP_ALU, OP_JMP, OP_JZ, OP_JPOS};
    endfunction

endpackage

// File: rtl/control_unit_program_counter.sv
// program_counter: 8-bit PC with jump load, increment
// and asynchronous reset to RESET_PC; wraps FF -> 00.
module program_counter #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_value,
    output logic [7:0] pc
);

    // jump load takes priority over the sequential increment
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_value;
        end else if (inc) begin
            pc <= pc + 8'd1;
        end
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: fetch/decode/execute sequencer for the 8-bit
// accumulator CPU. Optional macro CU_SINGLE_STEP_EN adds stepping.
module control_unit
    import cpu_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
`ifdef CU_SINGLE_STEP_EN
    input  logic       step_mode,
    input  logic       step,
`endif
    input  logic [7:0] imem_data,
    output logic [7:0] imem_addr,
    input  logic       user_enter,
    input  logic       zero_flag_in,
    input  logic       positive_flag_in,
    output logic [1:0] mux_select,
    output logic [7:0] imm_data,
    output logic       acc_enable,
    output logic [2:0] rf_address,
    output logic       rf_write,
    output logic [3:0] alu_select,
    output logic [1:0] alu_rotate,
    output logic       output_enable,
    output logic       halted
);

    state_t     state;
    state_t     state_n;
    logic [7:0] pc;
    logic [7:0] ir;
    logic [7:0] opr;
    logic       z_flag;
    logic       p_flag;
    logic       pc_inc;
    logic       pc_load;
    logic       addr_load;
    logic       ir_load;
    logic       opr_load;
    logic       fetch_go;
    logic [3:0] opcode;
    logic [3:0] field;

    assign opcode = ir[7:4];
    assign field  = ir[3:0];

`ifdef CU_SINGLE_STEP_EN
    logic step_q;
    logic step_pend;

    // registered step edge; one pending step is consumed per fetch
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            step_q    <= 1'b0;
            step_pend <= 1'b0;
        end else begin
            step_q <= step;
            if (step && !step_q) begin
                step_pend <= 1'b1;
            end else if (state == S_FETCH) begin
                step_pend <= 1'b0;
            end
        end
    end

    assign fetch_go = !step_mode || step_pend;
`else
    assign fetch_go = 1'b1;
`endif

    program_counter #(
        .RESET_PC(RESET_PC)
    ) u_pc (
        .clock     (clock),
        .reset     (reset),
        .inc       (pc_inc),
        .load      (pc_load),
        .load_value(opr),
        .pc        (pc)
    );

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_n;
        end
    end

    // ROM address, instruction/operand bytes and datapath flags
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            imem_addr <= RESET_PC;
            ir        <= 8'h00;
            opr       <= 8'h00;
            z_flag    <= 1'b1;
            p_flag    <= 1'b1;
        end else begin
            if (addr_load) imem_addr <= pc;
            if (ir_load)   ir <= imem_data;
            if (opr_load)  opr <= imem_data;
            if (acc_enable) begin
                z_flag <= zero_flag_in;
                p_flag <= positive_flag_in;
            end
        end
    end

    // next state, sequencing strobes and datapath controls
    always_comb begin
        state_n       = state;
        pc_inc        = 1'b0;
        pc_load       = 1'b0;
        addr_load     = 1'b0;
        ir_load       = 1'b0;
        opr_load      = 1'b0;
        mux_select    = MUX_ALU;
        imm_data      = 8'h00;
        acc_enable    = 1'b0;
        rf_address    = 3'd0;
        rf_write      = 1'b0;
        alu_select    = 4'd0;
        alu_rotate    = 2'd0;
        output_enable = 1'b0;
        halted        = 1'b0;
        unique case (state)
            S_FETCH: begin
                if (fetch_go) begin
                    addr_load = 1'b1;
                    pc_inc    = 1'b1;
                    state_n   = S_DECODE;
                end
            end
            S_DECODE: begin
                ir_load = 1'b1;
                state_n = is_two_byte(imem_data[7:4]) ? S_FETCH_OP
                                                      : S_EXECUTE;
            end
            S_FETCH_OP: begin
                addr_load = 1'b1;
                pc_inc    = 1'b1;
                state_n   = S_LOAD_OP;
            end
            S_LOAD_OP: begin
                opr_load = 1'b1;
                state_n  = S_EXECUTE;
            end
            S_EXECUTE: begin
                state_n = S_FETCH;
                unique case (1'b1)
                    (opcode == OP_IN):   state_n = S_WAIT_IN;
                    (opcode == OP_OUT):  output_enable = 1'b1;
                    (opcode == OP_MOVA): begin
                        mux_select = MUX_RF;
                        rf_address = field[2:0];
                        acc_enable = 1'b1;
                    end
                    (opcode == OP_MOVR): begin
                        rf_address = field[2:0];
                        rf_write   = 1'b1;
                    end
                    (opcode == OP_LDI): begin
                        mux_select = MUX_IMM;
                        imm_data   = opr;
                        acc_enable = 1'b1;
                    end
                    (opcode == OP_ALU): begin
                        mux_select = MUX_ALU;
                        alu_select = field;
                        alu_rotate = opr[7:6];
                        rf_address = opr[2:0];
                        acc_enable = 1'b1;
                    end
                    (opcode == OP_JMP):  pc_load = 1'b1;
                    (opcode == OP_JZ):   pc_load = z_flag;
                    (opcode == OP_JPOS): pc_load = p_flag;
                    (opcode == OP_HALT): state_n = S_HALT;
                    default: ;
                endcase
            end
            S_WAIT_IN: begin
                mux_select = MUX_USER;
                if (user_enter) begin
                    acc_enable = 1'b1;
                    state_n    = S_FETCH;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_n = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed and random programs for control_unit,
// compared cycle by cycle with an instruction-level model.
module tb_control_unit;

    logic       clock;
    logic       reset;
    logic [7:0] imem_data;
    logic [7:0] imem_addr;
    logic       user_enter;
    logic       zero_flag_in;
    logic       positive_flag_in;
    logic [1:0] mux_select;
    logic [7:0] imm_data;
    logic       acc_enable;
    logic [2:0] rf_address;
    logic       rf_write;
    logic [3:0] alu_select;
    logic [1:0] alu_rotate;
    logic       output_enable;
    logic       halted;
`ifdef CU_SINGLE_STEP_EN
    logic       step_mode;
    logic       step;
`endif

    control_unit #(
        .RESET_PC(8'h00)
    ) dut (
        .clock           (clock),
        .reset           (reset),
`ifdef CU_SINGLE_STEP_EN
        .step_mode       (step_mode),
        .step            (step),
`endif
        .imem_data       (imem_data),
        .imem_addr       (imem_addr),
        .user_enter      (user_enter),
        .zero_flag_in    (zero_flag_in),
        .positive_flag_in(positive_flag_in),
        .mux_select      (mux_select),
        .imm_data        (imm_data),
        .acc_enable      (acc_enable),
        .rf_address      (rf_address),
        .rf_write        (rf_write),
        .alu_select      (alu_select),
        .alu_rotate      (alu_rotate),
        .output_enable   (output_enable),
        .halted          (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // program ROM, read through the registered address
    logic [7:0] rom [0:255];
    assign imem_data = rom[imem_addr];

    // small datapath environment that produces the flags
    logic [7:0] dp_acc;
    logic [7:0] dp_rf [0:7];
    logic [7:0] acc_in;
    logic [7:0] user_val;

    function automatic logic [7:0] alu_f(input logic [3:0] s,
                                         input logic [1:0] r,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
        logic [7:0]  t;
        logic [15:0] d;
        t = (a + b) ^ {s, s};
        d = {t, t} << r;
        return d[15:8];
    endfunction

    always_comb begin
        case (mux_select)
            2'd0:    acc_in = alu_f(alu_select, alu_rotate, dp_acc,
                                    dp_rf[rf_address]);
            2'd1:    acc_in = dp_rf[rf_address];
            2'd2:    acc_in = imm_data;
            default: acc_in = user_val;
        endcase
    end

    assign zero_flag_in     = (acc_in == 8'h00);
    assign positive_flag_in = ~acc_in[7];

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            dp_acc <= 8'h00;
            for (int i = 0; i < 8; i++) dp_rf[i] <= 8'h00;
        end else begin
            if (acc_enable) dp_acc <= acc_in;
            if (rf_write) dp_rf[rf_address] <= dp_acc;
        end
    end

    logic [31:0] obs;
    assign obs = {1'b0, halted, output_enable, alu_rotate, alu_select,
                  rf_write, rf_address, acc_enable, imm_data,
                  mux_select, imem_addr};

    // instruction-level reference state
    logic [7:0] m_pc;
    logic [7:0] m_addr;
    logic [7:0] m_acc;
    logic [7:0] m_rf [0:7];
    logic       m_z;
    logic       m_p;
    logic       m_halted;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ev(input logic [1:0] mux,
                                       input logic [7:0] imm,
                                       input logic       ae,
                                       input logic [2:0] ra,
                                       input logic       rw,
                                       input logic [3:0] as,
                                       input logic [1:0] ar,
                                       input logic       oe,
                                       input logic       h);
        return {1'b0, h, oe, ar, as, rw, ra, ae, imm, mux, m_addr};
    endfunction

    function automatic logic [31:0] ez();
        return ev(2'd0, 8'h00, 1'b0, 3'd0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0);
    endfunction

    // one cycle: drive user_enter, compare, advance to next negedge
    task automatic cyc(input string tag, input logic [31:0] e,
                       input logic ue);
        user_enter = ue;
        #1;
        check(tag, obs, e);
        @(negedge clock);
    endtask

    task automatic set_acc(input logic [7:0] v);
        m_acc = v;
        m_z   = (v == 8'h00);
        m_p   = ~v[7];
    endtask

    task automatic run_instr(input int wait_n);
        logic [7:0] b0;
        logic [7:0] b1;
        logic [3:0] op;
        logic [3:0] f;
        int         w;
        b1 = 8'h00;
        cyc("fetch", ez(), 1'b0);
        m_addr = m_pc;
        m_pc   = m_pc + 8'd1;
        cyc("decode", ez(), 1'b0);
        b0 = rom[m_addr];
        op = b0[7:4];
        f  = b0[3:0];
        if (op inside {4'h5, 4'h6, 4'h7, 4'h8, 4'h9}) begin
            cyc("fetch_op", ez(), 1'b0);
            m_addr = m_pc;
            m_pc   = m_pc + 8'd1;
            cyc("load_op", ez(), 1'b0);
            b1 = rom[m_addr];
        end
        case (op)
            4'h1: begin
                cyc("exec_in", ez(), 1'b0);
                w = (wait_n < 0) ? int'($urandom_range(0, 4)) : wait_n;
                user_val = 8'($urandom);
                repeat (w) cyc("wait_in", ev(2'd3, 8'h00, 1'b0, 3'd0, 1'b0,
                                             4'd0, 2'd0, 1'b0, 1'b0), 1'b0);
                cyc("enter", ev(2'd3, 8'h00, 1'b1, 3'd0, 1'b0, 4'd0, 2'd0,
                                1'b0, 1'b0), 1'b1);
                set_acc(user_val);
            end
            4'h2: cyc("out", ev(2'd0, 8'h00, 1'b0, 3'd0, 1'b0, 4'd0, 2'd0,
                                1'b1, 1'b0), 1'b0);
            4'h3: begin
                cyc("mova", ev(2'd1, 8'h00, 1'b1, f[2:0], 1'b0, 4'd0, 2'd0,
                               1'b0, 1'b0), 1'b0);
                set_acc(m_rf[f[2:0]]);
            end
            4'h4: begin
                cyc("movr", ev(2'd0, 8'h00, 1'b0, f[2:0], 1'b1, 4'd0, 2'd0,
                               1'b0, 1'b0), 1'b0);
                m_rf[f[2:0]] = m_acc;
            end
            4'h5: begin
                cyc("ldi", ev(2'd2, b1, 1'b1, 3'd0, 1'b0, 4'd0, 2'd0,
                              1'b0, 1'b0), 1'b0);
                set_acc(b1);
            end
            4'h6: begin
                cyc("alu", ev(2'd0, 8'h00, 1'b1, b1[2:0], 1'b0, f, b1[7:6],
                              1'b0, 1'b0), 1'b0);
                set_acc(alu_f(f, b1[7:6], m_acc, m_rf[b1[2:0]]));
            end
            4'h7: begin
                cyc("jmp", ez(), 1'b0);
                m_pc = b1;
            end
            4'h8: begin
                cyc("jz", ez(), 1'b0);
                if (m_z) m_pc = b1;
            end
            4'h9: begin
                cyc("jpos", ez(), 1'b0);
                if (m_p) m_pc = b1;
            end
            4'hF: begin
                cyc("exec_halt", ez(), 1'b0);
                m_halted = 1'b1;
            end
            default: cyc("nop", ez(), 1'b0);
        endcase
    endtask

    task automatic halt_cycles(input int n);
        repeat (n) cyc("halt", ev(2'd0, 8'h00, 1'b0, 3'd0, 1'b0, 4'd0,
                                  2'd0, 1'b0, 1'b1), 1'b0);
    endtask

    task automatic run_prog(input int max_instr);
        for (int i = 0; i < max_instr && !m_halted; i++) run_instr(-1);
        if (m_halted) halt_cycles(4);
    endtask

    // asynchronous reset in the middle of a cycle
    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        check("async_rst", obs, 32'h0);
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    task automatic start();
        m_pc     = 8'h00;
        m_addr   = 8'h00;
        m_acc    = 8'h00;
        m_z      = 1'b1;
        m_p      = 1'b1;
        m_halted = 1'b0;
        for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        reset      = 1'b1;
        user_enter = 1'b0;
        user_val   = 8'h00;
`ifdef CU_SINGLE_STEP_EN
        step_mode  = 1'b0;
        step       = 1'b0;
`endif
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        #1 reset = 1'b0;
        #1 check("por", obs, 32'h0);

        // LDI 2A; OUT; HALT
        rom[0] = 8'h51; rom[1] = 8'h2A; rom[2] = 8'h20; rom[3] = 8'hF0;
        start();
        run_prog(10);
        check("halted_addr", {24'h0, imem_addr}, 32'h3);

        // IN with a long wait, OUT, then reset while waiting
        do_reset();
        rom[0] = 8'h10; rom[1] = 8'h20; rom[2] = 8'h10; rom[3] = 8'hF0;
        start();
        run_instr(10);
        run_instr(0);
        cyc("fetch", ez(), 1'b0);
        m_addr = m_pc;
        m_pc   = m_pc + 8'd1;
        cyc("decode", ez(), 1'b0);
        cyc("exec_in", ez(), 1'b0);
        cyc("wait_in", ev(2'd3, 8'h00, 1'b0, 3'd0, 1'b0, 4'd0, 2'd0,
                          1'b0, 1'b0), 1'b0);

        // LDI 0; JZ 10 | LDI 80; JPOS 20 untaken -> HALT at 14
        do_reset();
        rom[8'h00] = 8'h50; rom[8'h01] = 8'h00;
        rom[8'h02] = 8'h80; rom[8'h03] = 8'h10;
        rom[8'h04] = 8'hF0;
        rom[8'h10] = 8'h50; rom[8'h11] = 8'h80;
        rom[8'h12] = 8'h90; rom[8'h13] = 8'h20;
        rom[8'h14] = 8'hF0; rom[8'h20] = 8'hF0;
        start();
        run_prog(10);
        check("branch_end", {24'h0, imem_addr}, 32'h14);

        // LDI 5; MOVR 3; ALU F=2 byte1=01_000_011; HALT
        do_reset();
        rom[0] = 8'h50; rom[1] = 8'h05; rom[2] = 8'h43;
        rom[3] = 8'h62; rom[4] = 8'h43; rom[5] = 8'hF0;
        start();
        run_prog(10);

        // PC wrap: LDI at FF takes its operand from 00
        do_reset();
        rom[8'h00] = 8'h00; rom[8'h01] = 8'h70;
        rom[8'h02] = 8'hFF; rom[8'hFF] = 8'h50;
        start();
        run_instr(-1);
        run_instr(-1);
        run_instr(-1);
        run_instr(-1);
        cyc("fetch", ez(), 1'b0);
        m_addr = m_pc;
        m_pc   = m_pc + 8'd1;
        cyc("decode", ez(), 1'b0);
        do_reset();

`ifdef CU_SINGLE_STEP_EN
        rom[0] = 8'h50; rom[1] = 8'h33; rom[2] = 8'h20; rom[3] = 8'h43;
        step_mode = 1'b1;
        start();
        repeat (20) cyc("step_stall", ez(), 1'b0);
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            cyc("step_arm", ez(), 1'b0);
            run_instr(0);
            step = 1'b0;
            repeat (3) cyc("step_idle", ez(), 1'b0);
        end
        step_mode = 1'b0;
        do_reset();
`endif

        // random programs
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 256; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                if (b[7:4] == 4'hF && $urandom_range(0, 3) != 0) b[7:4] = 4'h0;
                rom[i] = b;
            end
            start();
            run_prog(40);
            do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
